// File: rtl/drum_hit_detector.sv
// Drum-pad strike detector on the XADC conversion stream: finds the peak over a
// fixed number of drdy samples, emits a hit pulse with 7-bit velocity, then locks out ringing.
module drum_hit_detector #(
  parameter logic [11:0] THRESHOLD      = 12'h200,
  parameter logic [11:0] RELEASE        = 12'h100,
  parameter int unsigned PEAK_SAMPLES   = 8,
  parameter logic [15:0] HOLDOFF_CYCLES = 16'd50000
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        drdy,
  input  logic [15:0] data_in,
  output logic        hit,
  output logic [6:0]  velocity,
  output logic [7:0]  hit_count,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ATTACK, HOLDOFF} state_t;

  localparam logic [7:0] LAST_IDX = 8'(PEAK_SAMPLES - 1);

  state_t      state, state_next;
  logic [11:0] peak;
  logic [7:0]  win_cnt;
  logic [15:0] hold_cnt;

  logic [11:0] sample;
  logic [11:0] peak_max;
  logic        trigger;
  logic        window_done;
  logic        unused_nibble;

  assign sample        = data_in[15:4];
  assign unused_nibble = ^data_in[3:0];
  assign peak_max      = (sample > peak) ? sample : peak;
  assign busy          = (state != IDLE);

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned -- otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_next  = state;
    trigger     = 1'b0;
    window_done = 1'b0;
    case (state)
      IDLE: begin
        if (drdy && sample >= THRESHOLD) begin
          trigger    = 1'b1;
          state_next = ATTACK;
        end
      end
      ATTACK: begin
        // Sub-threshold samples inside the window still count toward it.
        if (drdy && win_cnt == LAST_IDX) begin
          window_done = 1'b1;
          state_next  = HOLDOFF;
        end
      end
      HOLDOFF: begin
        // Only a quiet sample after the hold-off timer expires re-arms the pad.
        if (hold_cnt == 16'd0 && drdy && sample < RELEASE) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      hit       <= 1'b0;
      velocity  <= 7'd0;
      hit_count <= 8'd0;
      peak      <= 12'd0;
      win_cnt   <= 8'd0;
      hold_cnt  <= 16'd0;
    end else begin
      hit <= window_done;

      if (trigger) begin
        peak    <= sample;
        win_cnt <= 8'd1;
      end else if (state == ATTACK && drdy && !window_done) begin
        peak    <= peak_max;
        win_cnt <= win_cnt + 8'd1;
      end

      if (window_done) begin
        velocity  <= peak_max[11:5];
        hit_count <= hit_count + 8'd1;
        hold_cnt  <= HOLDOFF_CYCLES;
      end else if (state == HOLDOFF && hold_cnt != 16'd0) begin
        hold_cnt <= hold_cnt - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_drum_hit_detector.sv
// Randomized scoreboard bench for drum_hit_detector: a window-level reference model
// predicts each hit, a negedge monitor pops and compares whenever hit pulses.
module tb_drum_hit_detector;

  localparam logic [11:0] THR = 12'h200;
  localparam logic [11:0] REL = 12'h100;
  localparam int          P   = 4;
  localparam int          H   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        drdy = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic        hit;
  logic [6:0]  velocity;
  logic [7:0]  hit_count;
  logic        busy;

  drum_hit_detector #(
    .THRESHOLD(THR), .RELEASE(REL), .PEAK_SAMPLES(P), .HOLDOFF_CYCLES(16'(H))
  ) dut (
    .CLK100MHZ(clk), .reset(rst), .drdy(drdy), .data_in(data_in),
    .hit(hit), .velocity(velocity), .hit_count(hit_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         stamp;
    logic [6:0] vel;
    logic [7:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          hits_seen = 0;

  // Reference model state: 0 idle, 1 collecting window, 2 locked out.
  int          m_mode = 0;
  int          m_cnt  = 0;
  int          m_hit_cyc = 0;
  logic [11:0] m_win[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Model: a strike is the PEAK_SAMPLES drdy samples starting at the trigger;
  // velocity is the top 7 bits of their maximum. Re-arm needs the timer expired
  // (more than H clocks since the hit edge) and a sample below RELEASE.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_mode = 0;
        m_cnt  = 0;
        m_win.delete();
        exp_q.delete();
      end else if (drdy) begin
        logic [11:0] s;
        s = data_in[15:4];
        case (m_mode)
          0: if (s >= THR) begin
               m_win.delete();
               m_win.push_back(s);
               m_mode = 1;
             end
          1: begin
               m_win.push_back(s);
               if (m_win.size() == P) begin
                 logic [11:0] mx;
                 exp_t e;
                 mx = 0;
                 foreach (m_win[i]) if (m_win[i] > mx) mx = m_win[i];
                 m_cnt = (m_cnt + 1) % 256;
                 e.stamp = cyc;
                 e.vel   = mx[11:5];
                 e.cnt   = 8'(m_cnt);
                 exp_q.push_back(e);
                 m_hit_cyc = cyc;
                 m_mode = 2;
               end
             end
          default: if (cyc - m_hit_cyc > H && s < REL) m_mode = 0;
        endcase
      end
    end
  end

  // Monitor: busy every cycle; on each hit pop the scoreboard and compare.
  initial begin
    forever begin
      @(negedge clk);
      check("busy", {31'd0, busy}, {31'd0, m_mode != 0});
      if (hit) begin
        hits_seen++;
        if (exp_q.size() == 0) begin
          check("hit_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("hit_cycle", cyc, e.stamp);
          check("velocity", {25'd0, velocity}, {25'd0, e.vel});
          check("hit_count", {24'd0, hit_count}, {24'd0, e.cnt});
        end
      end else if (exp_q.size() != 0 && exp_q[0].stamp <= cyc) begin
        check("hit_missing", 32'd0, 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [11:0] s, input int gap);
    repeat (gap) @(negedge clk);
    drdy    = 1'b1;
    data_in = {s, 4'($urandom)};
    @(negedge clk);
    drdy    = 1'b0;
    data_in = 16'($urandom);
  endtask

  task automatic quiet_release(input int gap);
    repeat (H + 2) @(negedge clk);
    send(12'($urandom_range(0, 12'h0FF)), gap);
  endtask

  task automatic random_strike(input int max_gap, input int ring);
    send(12'($urandom_range(THR, 12'hFFF)), $urandom_range(0, max_gap));
    for (int i = 1; i < P; i++) send(12'($urandom), $urandom_range(0, max_gap));
    for (int i = 0; i < ring; i++) send(12'($urandom), $urandom_range(0, 3));
    quiet_release($urandom_range(0, max_gap));
  endtask

  initial begin
    int base;
    logic [11:0] strike[5];

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_hit", {31'd0, hit}, 32'd0);
    check("reset_velocity", {25'd0, velocity}, 32'd0);
    check("reset_hit_count", {24'd0, hit_count}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a window: busy drops at once and no hit follows.
    send(12'h300, 1);
    send(12'h400, 1);
    check("attack_busy", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1 check("async_reset_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("no_hit_after_reset", {24'd0, hit_count}, 32'd0);

    // Single strike, directed.
    strike = '{12'h080, 12'h300, 12'h7F0, 12'hA40, 12'h500};
    foreach (strike[i]) send(strike[i], 1);
    @(negedge clk);
    check("single_velocity", {25'd0, velocity}, 32'h52);
    check("single_count", {24'd0, hit_count}, 32'd1);
    quiet_release(1);

    // Sub-threshold signal never triggers.
    base = hits_seen;
    repeat (20) send(12'h1FF, 0);
    check("subthresh_no_hit", hits_seen - base, 32'd0);

    // Ringing lockout: 0x400 samples keep HOLDOFF, 0x0F0 releases.
    base = hits_seen;
    send(12'h300, 0); send(12'h600, 0); send(12'h200, 0); send(12'h100, 0);
    repeat (30) send(12'h400, 2);
    check("ringing_still_busy", {31'd0, busy}, 32'd1);
    send(12'h0F0, 1);
    check("ringing_released", {31'd0, busy}, 32'd0);
    check("ringing_one_hit", hits_seen - base, 32'd1);

    // Sparse drdy: one strobe every 37 clocks.
    send(12'h300, 36); send(12'h7F0, 36); send(12'hA40, 36); send(12'h500, 36);
    @(negedge clk);
    check("sparse_velocity", {25'd0, velocity}, 32'h52);
    check("sparse_count", {24'd0, hit_count}, 32'd3);
    quiet_release(36);

    // Randomized strikes with noise and ringing in between.
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) send(12'($urandom_range(0, THR - 1)), $urandom_range(0, 4));
      random_strike(3, $urandom_range(0, 4));
    end

    // Counter wrap: 256 strikes from reset.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = hits_seen;
    for (int n = 0; n < 256; n++) random_strike(2, 0);
    check("wrap_count", {24'd0, hit_count}, 32'd0);
    check("wrap_hits", hits_seen - base, 32'd256);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/drum_hit_detector.md
# drum_hit_detector

Detects drum-pad strikes in the XADC conversion stream. Sits directly downstream of the XADC wrapper and consumes its 16-bit conversion result and data-ready strobe. For each strike it finds the peak amplitude inside a short window, then emits a one-cycle hit pulse with a 7-bit velocity. A hold-off and release hysteresis prevent the pad's ringing from retriggering.

## Interface
- THRESHOLD, 12'h200: 12-bit sample level at or above which a strike starts.
- RELEASE, 12'h100: 12-bit level below which the pad counts as quiet. Must be < THRESHOLD.
- PEAK_SAMPLES, 8: number of drdy samples in the peak window, including the triggering sample. Legal range 2..255.
- HOLDOFF_CYCLES, 16'd50000: minimum number of CLK100MHZ cycles spent in HOLDOFF after a hit. Legal range 1..65535.
- CLK100MHZ  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- drdy  in  1  one-cycle strobe; data_in is valid in that cycle.
- data_in  in  16  XADC result, MSB-aligned; sample = data_in[15:4]; data_in[3:0] is ignored.
- hit  out  1  one-cycle pulse per detected strike.
- velocity  out  7  peak[11:5] of the last strike; holds its value until the next hit.
- hit_count  out  8  number of strikes since reset; wraps 255 -> 0.
- busy  out  1  high whenever state != IDLE.

## Operation
- Internal registers:
  - state: IDLE, ATTACK or HOLDOFF.
  - peak: 12 bits.
  - win_cnt: 8 bits.
  - hold_cnt: 16 bits.
- Samples are evaluated only in cycles with drdy=1. Unsigned compares throughout.
- IDLE:
  - On drdy with sample >= THRESHOLD: peak <= sample, win_cnt <= 1, go to ATTACK.
  - Otherwise stay in IDLE.
- ATTACK, on drdy:
  - m = max(peak, sample).
  - If win_cnt == PEAK_SAMPLES-1 (final sample of the window):
    - velocity <= m[11:5] and hit <= 1.
    - hit_count <= hit_count+1.
    - hold_cnt <= HOLDOFF_CYCLES.
    - Go to HOLDOFF.
  - Otherwise: peak <= m, win_cnt <= win_cnt+1.
  - Samples falling below THRESHOLD inside the window do not abort it.
- HOLDOFF:
  - Each clock, hold_cnt decrements if it is nonzero.
  - When hold_cnt == 0 and drdy arrives with sample < RELEASE: go to IDLE.
  - While hold_cnt == 0, samples >= RELEASE keep the block in HOLDOFF indefinitely (pad still ringing).
  - Samples are otherwise ignored; no hit can be emitted in this state.
- hit is a registered pulse. It is cleared every cycle unless set by the ATTACK exit in the same cycle.
- busy is a combinational decode of state.

## Timing
- Reset values: state=IDLE, hit=0, velocity=0, hit_count=0, busy=0, peak=0, win_cnt=0, hold_cnt=0.
- Reset is asynchronous. Asserting it at any point, including mid-ATTACK or mid-HOLDOFF, returns to the reset values at once. No pending hit is emitted.
- Latency: hit and the new velocity appear the cycle after the clock edge that samples the final window drdy. The same applies to the hit_count increment.
- velocity is stable and valid in the cycle where hit=1, and afterwards.
- A strike needs exactly PEAK_SAMPLES drdy strobes from the trigger, regardless of how many clocks separate them.
- Gaps between drdy strobes are arbitrary. Back-to-back drdy on consecutive clocks is legal.
- Minimum spacing between two hits: PEAK_SAMPLES drdy strobes plus HOLDOFF_CYCLES clocks plus one quiet drdy.
- The first IDLE cycle after leaving HOLDOFF can trigger on the next drdy.
- hit_count wrap: 8'hFF + 1 -> 8'h00, and hit still pulses.
- drdy with X/garbage data while in HOLDOFF with hold_cnt != 0 has no effect.

## Test plan
Bench parameters: THRESHOLD=12'h200, RELEASE=12'h100, PEAK_SAMPLES=4, HOLDOFF_CYCLES=16.
- Reset: hold reset high, then release it with drdy=0. Required: hit=0, velocity=0, hit_count=0, busy=0.
  - Assert reset while in ATTACK. Required: busy drops immediately and no hit follows.
- Single strike: drdy samples 0x080, 0x300, 0x7F0, 0xA40, 0x500, then quiet 0x020.
  - Required: trigger on 0x300.
  - Required: hit pulses once, exactly one cycle after the 0x500 drdy edge.
  - Required: velocity=0xA40>>5=7'h52 and hit_count=1.
- Sub-threshold signal: drdy samples 0x1FF repeated 20 times. Required: busy stays 0 and no hit.
- Ringing lockout: after a hit, send 30 drdy samples of 0x400 spread over 100 clocks, then 0x0F0.
  - Required: no hit during the 0x400 samples.
  - Required: return to IDLE only on the 0x0F0 drdy, which occurs after hold_cnt has reached 0.
- Sparse drdy: same strike as the single-strike case, with drdy every 37 clocks.
  - Required: identical velocity, and hit appears one cycle after the 4th window strobe.
- Counter wrap: 256 strikes. Required: hit_count reads 0x00 after the 256th hit, and each strike produces exactly one hit pulse.
